lms_tap_sequencer: RTL



---
 rtl/lms_tap_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/lms_tap_sequencer.sv
// ---------------------------------------------------------------------------
// lms_tap_sequencer
// Time-multiplexes one shared LMS datapath over all N_TAPS taps for each
// accepted audio sample. A pass writes the new reference sample into the
// circular delay line, then walks every tap once. On each tap the datapath
// filters (y += w*x) and updates the weight (w += mu*e*x) together.
// A pass is N_TAPS + PIPE_LAT + 2 cycles long.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   sample handshake; in_ready is high only in IDLE
//   error_in, mu_in     Q1.15 error and step size, latched on accept
//   freeze              suppresses weight writes for a pass (sampled in LOAD)
//   ovr_clr             clears the sticky overrun flag
//   e_lat, mu_lat       latched error / step size to the datapath
//   x_we, x_waddr       delay-line write strobe and head address
//   rd_en, w_raddr,
//   x_raddr             weight / delay-line read strobe and addresses
//   acc_clr, acc_en     accumulator clear / accumulate enable
//   w_we, w_waddr       weight write strobe and address
//   out_valid           one-cycle pulse when the accumulator holds final y
//   overrun             sticky flag: a sample arrived while busy
//   sample_cnt          count of accepted samples (wraps)
// ---------------------------------------------------------------------------
module lms_tap_sequencer #(
   parameter int N_TAPS   = 128,
   parameter int ADDR_W   = 7,
   parameter int PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       error_in,
   input  logic [15:0]       mu_in,
   input  logic              freeze,
   input  logic              ovr_clr,
   output logic [15:0]       e_lat,
   output logic [15:0]       mu_lat,
   output logic              x_we,
   output logic [ADDR_W-1:0] x_waddr,
   output logic              rd_en,
   output logic [ADDR_W-1:0] w_raddr,
   output logic [ADDR_W-1:0] x_raddr,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              w_we,
   output logic [ADDR_W-1:0] w_waddr,
   output logic              out_valid,
   output logic              overrun,
   output logic [15:0]       sample_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ADDR_W-1:0] tap_r;
   logic [ADDR_W-1:0] tap_nxt_s;
   logic [2:0]        drn_r;
   logic [2:0]        drn_nxt_s;
   logic [ADDR_W-1:0] head_r;
   logic [ADDR_W-1:0] head_nxt_s;
   logic              frz_r;
   logic              accept_s;
   logic              drop_s;

   // Delay registers that align write-back and accumulate with the read latency.
   logic [PIPE_LAT-1:0] en_pipe_r;
   logic [PIPE_LAT-1:0] we_pipe_r;
   logic [ADDR_W-1:0]   addr_pipe_r [PIPE_LAT];

   // Ready is a pure state decode so the front end sees it in the same cycle.
   assign in_ready = (state_r == ST_IDLE);
   assign accept_s = in_valid & (state_r == ST_IDLE);
   assign drop_s   = in_valid & (state_r != ST_IDLE);

   assign acc_en  = en_pipe_r[PIPE_LAT-1];
   assign w_we    = we_pipe_r[PIPE_LAT-1];
   assign w_waddr = addr_pipe_r[PIPE_LAT-1];

   // Next-state, tap counter and drain counter.
   always_comb begin
      state_nxt_s = state_r;
      tap_nxt_s   = tap_r;
      drn_nxt_s   = drn_r;
      head_nxt_s  = head_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_LOAD;
               // The delay line grows downward, so the newest sample sits at head.
               head_nxt_s  = head_r - ADDR_W'(1);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_nxt_s = ST_RUN;
            tap_nxt_s   = '0;
         end
         ST_RUN: begin
            if (tap_r == ADDR_W'(N_TAPS - 1)) begin
               state_nxt_s = ST_DRAIN;
               tap_nxt_s   = '0;
               drn_nxt_s   = 3'd0;
            end else begin
               tap_nxt_s   = tap_r + ADDR_W'(1);
            end
         end
         ST_DRAIN: begin
            if (drn_r == 3'(PIPE_LAT - 1)) begin
               state_nxt_s = ST_DONE;
               drn_nxt_s   = 3'd0;
            end else begin
               drn_nxt_s   = drn_r + 3'd1;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            tap_nxt_s   = '0;
            drn_nxt_s   = 3'd0;
         end
      endcase
   end

   // State, counters, head pointer and freeze latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         tap_r   <= '0;
         drn_r   <= 3'd0;
         head_r  <= '0;
         frz_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         tap_r   <= tap_nxt_s;
         drn_r   <= drn_nxt_s;
         head_r  <= head_nxt_s;
         if (state_r == ST_LOAD) begin
            frz_r <= freeze;
         end else begin
            frz_r <= frz_r;
         end
      end
   end

   // Registered strobes and addresses, decoded from the next state so they
   // line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_we      <= 1'b0;
         x_waddr   <= '0;
         acc_clr   <= 1'b0;
         rd_en     <= 1'b0;
         w_raddr   <= '0;
         x_raddr   <= '0;
         out_valid <= 1'b0;
      end else begin
         x_we      <= (state_nxt_s == ST_LOAD);
         acc_clr   <= (state_nxt_s == ST_LOAD);
         x_waddr   <= accept_s ? head_nxt_s : x_waddr;
         rd_en     <= (state_nxt_s == ST_RUN);
         // Reads start at the newest sample and walk towards older ones.
         w_raddr   <= (state_nxt_s == ST_RUN) ? tap_nxt_s : '0;
         x_raddr   <= (state_nxt_s == ST_RUN) ? (head_r + tap_nxt_s) : '0;
         out_valid <= (state_nxt_s == ST_DONE);
      end
   end

   // Read-to-write-back alignment pipeline; freeze gates only the write strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_pipe_r <= '0;
         we_pipe_r <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            addr_pipe_r[i] <= '0;
         end
      end else begin
         en_pipe_r[0]   <= rd_en;
         we_pipe_r[0]   <= rd_en & ~frz_r;
         addr_pipe_r[0] <= w_raddr;
         for (int i = 1; i < PIPE_LAT; i++) begin
            en_pipe_r[i]   <= en_pipe_r[i-1];
            we_pipe_r[i]   <= we_pipe_r[i-1];
            addr_pipe_r[i] <= addr_pipe_r[i-1];
         end
      end
   end

   // Latched operands, sample counter and sticky overrun (set beats clear).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_lat      <= 16'd0;
         mu_lat     <= 16'd0;
         sample_cnt <= 16'd0;
         overrun    <= 1'b0;
      end else begin
         if (accept_s) begin
            e_lat      <= error_in;
            mu_lat     <= mu_in;
            sample_cnt <= sample_cnt + 16'd1;
         end else begin
            e_lat      <= e_lat;
            mu_lat     <= mu_lat;
            sample_cnt <= sample_cnt;
         end
         if (drop_s) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end else begin
            overrun <= overrun;
         end
      end
   end

endmodule
